wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports i_clk and i_rst.
REQ-002 Port i_clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-003 Port i_rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-004 Port i_valid, input, 1 bit, SHALL mean the MEM/WB entry is valid.
REQ-005 Port i_stall, input, 1 bit, SHALL mean insert a bubble this cycle because upstream holds.
REQ-006 Port i_flush, input, 1 bit, SHALL mean kill the incoming entry.
REQ-007 Port i_rd_we, input, 1 bit, SHALL mean the instruction writes rd.
REQ-008 Port i_rd_addr, input, 5 bits, SHALL carry the destination register index.
REQ-009 Port i_wb_sel, input, 2 bits, SHALL select the source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-010 Port i_alu_result, input, 32 bits, SHALL carry the ALU result and, for loads, the effective address.
REQ-011 Port i_ld_data, input, 32 bits, SHALL carry the raw aligned memory word.
REQ-012 Port i_ld_funct3, input, 3 bits, SHALL carry the load funct3.
REQ-013 Port i_pc, input, 32 bits, SHALL carry the instruction PC.
REQ-014 Port o_rd_wren, output, 1 bit, SHALL be the register-file write enable to decode.
REQ-015 Port o_rd_addr, output, 5 bits, SHALL be the register-file write index.
REQ-016 Port o_rd_data, output, 32 bits, SHALL be the register-file write data.
REQ-017 Port o_retire, output, 1 bit, SHALL pulse for one cycle per retired instruction.
REQ-018 Port o_instret, output, 32 bits, SHALL be the retired-instruction count.

Function
REQ-019 The stage register SHALL capture all inputs on every rising edge, with latency of exactly 1 cycle from input to o_rd_*.
REQ-020 The captured valid bit SHALL equal i_valid & ~i_stall & ~i_flush; when i_stall or i_flush is high, a bubble SHALL be loaded regardless of i_valid.
REQ-021 o_rd_wren SHALL equal reg_valid & reg_rd_we & (reg_rd_addr != 0); writes to x0 SHALL always be suppressed.
REQ-022 o_rd_addr SHALL equal reg_rd_addr unconditionally.
REQ-023 o_rd_data SHALL be registered-ALU for sel 00, load-extended data for sel 01, reg_pc+4 (mod 2^32) for sel 10, and 0 for sel 11.
REQ-024 The load byte offset SHALL be reg_alu_result[1:0].
REQ-025 For LB (000) and LBU (100), the selected byte SHALL be word[8*off+7:8*off], sign-extended for LB and zero-extended for LBU.
REQ-026 For LH (001) and LHU (101), the halfword SHALL be selected by off[1], with off[0] ignored, sign-extended for LH and zero-extended for LHU.
REQ-027 For LW (010) and for any other funct3 value, the full word SHALL be used with the offset ignored.
REQ-028 o_retire SHALL equal reg_valid, independent of rd_we and of rd_addr.
REQ-029 o_instret SHALL increment by 1 on each edge where o_retire is 1, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 When i_rst is high at a rising edge, reg_valid SHALL be cleared and all stage-register fields and o_instret SHALL be zeroed.
REQ-031 While in reset, the outputs SHALL be o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_retire=0 and o_instret=0.
REQ-032 i_rst SHALL have priority over i_valid, i_stall and i_flush, including mid-stream, and an entry present before reset SHALL neither write nor retire.

Configuration
REQ-033 The block SHALL use the macro WB_INSTRET_EN to include or exclude the retire counter.
REQ-034 When WB_INSTRET_EN is defined, the counter SHALL be present and SHALL behave per REQ-029.
REQ-035 When WB_INSTRET_EN is undefined, the counter register SHALL be absent, o_instret SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-036 Reset for 4 cycles, then release with i_valid=0 -> all outputs are 0 and o_instret=0.
REQ-037 Drive i_valid=1, i_rd_we=1, i_rd_addr=2, i_wb_sel=00, i_alu_result=0x00410133 -> one cycle later o_rd_wren=1, o_rd_addr=2, o_rd_data=0x00410133, o_retire=1, o_instret becomes 1.
REQ-038 Issue a load with i_ld_data=0x8081F0F7 and i_alu_result[1:0]=01 -> LB gives 0xFFFFFFF0, LBU gives 0x000000F0, LH gives 0xFFFFF0F7, LHU gives 0x0000F0F7, LW gives 0x8081F0F7.
REQ-039 Issue i_wb_sel=10 with i_pc=0xFFFFFFFC -> o_rd_data=0x00000000; issue any valid write with i_rd_addr=0 -> o_rd_wren=0 and o_retire=1.
REQ-040 Hold i_valid=1 while i_stall=1 for 2 cycles, then apply i_flush=1 for 1 cycle -> o_rd_wren=0 and o_retire=0 for 3 cycles, and o_instret is unchanged.
REQ-041 With WB_INSTRET_EN defined, preload the counter via 0xFFFFFFFF retires (or force it) then retire once more -> o_instret=0; with the macro undefined, o_instret is 0 always.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus write-back mux and load extension.
//
// Ports
//   i_clk, i_rst       rising-edge clock, synchronous active-high reset
//   i_valid            MEM/WB entry valid
//   i_stall, i_flush   force a bubble into the stage register
//   i_rd_we, i_rd_addr destination write enable / index
//   i_wb_sel           00 ALU, 01 load, 10 PC+4, 11 reserved (data 0)
//   i_alu_result       ALU result, or effective address for loads
//   i_ld_data          raw aligned memory word
//   i_ld_funct3        load funct3 (LB/LH/LW/LBU/LHU)
//   i_pc               instruction PC
//   o_rd_wren/addr/data register-file write port
//   o_retire           one pulse per retired instruction
//   o_instret          retired-instruction count
//
// Build option: define WB_INSTRET_EN to include the retire counter;
// otherwise o_instret is tied to 0.
module wb_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_rd_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_ld_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [31:0] i_pc,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_retire,
  output logic [31:0] o_instret
);

  logic        valid_q;
  logic        valid_d;
  logic        rd_we_q;
  logic [4:0]  rd_addr_q;
  logic [1:0]  wb_sel_q;
  logic [31:0] alu_q;
  logic [31:0] ld_data_q;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] rd_data;

  assign valid_d = i_valid & ~i_stall & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      wb_sel_q  <= '0;
      alu_q     <= '0;
      ld_data_q <= '0;
      funct3_q  <= '0;
      pc_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_we_q   <= i_rd_we;
      rd_addr_q <= i_rd_addr;
      wb_sel_q  <= i_wb_sel;
      alu_q     <= i_alu_result;
      ld_data_q <= i_ld_data;
      funct3_q  <= i_ld_funct3;
      pc_q      <= i_pc;
    end
  end

  // Load lane select: byte by full offset, halfword by offset bit 1 only.
  always_comb begin
    ld_byte = 8'h00;
    case (alu_q[1:0])
      2'b00: ld_byte = ld_data_q[7:0];
      2'b01: ld_byte = ld_data_q[15:8];
      2'b10: ld_byte = ld_data_q[23:16];
      2'b11: ld_byte = ld_data_q[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = alu_q[1] ? ld_data_q[31:16] : ld_data_q[15:0];
  end

  // Unknown funct3 values fall through to a full-word load.
  always_comb begin
    ld_ext = ld_data_q;
    case (funct3_q)
      3'b000: ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_ext = {24'h0, ld_byte};
      3'b001: ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101: ld_ext = {16'h0, ld_half};
      default: ld_ext = ld_data_q;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    case (wb_sel_q)
      2'b00: rd_data = alu_q;
      2'b01: rd_data = ld_ext;
      2'b10: rd_data = pc_q + 32'd4;
      default: rd_data = 32'h0;
    endcase
  end

  // Outputs are held at zero while reset is asserted so an entry captured
  // before reset can neither write nor retire during the reset cycle.
  assign o_rd_wren = ~i_rst & valid_q & rd_we_q & (rd_addr_q != 5'd0);
  assign o_rd_addr = i_rst ? 5'd0 : rd_addr_q;
  assign o_rd_data = i_rst ? 32'h0 : rd_data;
  assign o_retire  = ~i_rst & valid_q;

`ifdef WB_INSTRET_EN
  logic [31:0] instret_q;
  logic [31:0] instret_d;

  assign instret_d = instret_q + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instret_q <= '0;
    end else if (valid_q) begin
      instret_q <= instret_d;
    end
  end

  assign o_instret = i_rst ? 32'h0 : instret_q;
`else
  assign o_instret = 32'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, stall, flush, rd_we;
  logic [4:0]  rd_addr;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result, ld_data, pc;
  logic [2:0]  ld_funct3;
  logic        o_rd_wren, o_retire;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data, o_instret;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: what the stage holds after the last edge
  logic        m_v;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_rd_we      (rd_we),
    .i_rd_addr    (rd_addr),
    .i_wb_sel     (wb_sel),
    .i_alu_result (alu_result),
    .i_ld_data    (ld_data),
    .i_ld_funct3  (ld_funct3),
    .i_pc         (pc),
    .o_rd_wren    (o_rd_wren),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_retire     (o_retire),
    .o_instret    (o_instret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result from the ISA definition: shift the word down by the byte
  // offset, then truncate and extend according to the load width.
  function automatic logic [31:0] load_value(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] sh;
    int unsigned b, h;
    sh = w >> (8 * int'(off));
    b  = int'(sh) & 32'hFF;
    h  = int'(w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd4: return 32'(b);
      3'd1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd5: return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wb_value();
    case (wb_sel)
      2'd0: return alu_result;
      2'd1: return load_value(ld_data, alu_result[1:0], ld_funct3);
      2'd2: return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: advance the model on the edge, check all outputs just after
  // it, then return at the falling edge ready for new inputs.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    end else begin
      if (m_v) m_cnt = m_cnt + 32'd1;
      m_v    = valid && !stall && !flush;
      m_we   = rd_we;
      m_addr = rd_addr;
      m_data = wb_value();
    end
    #1;
    if (rst) begin
      chk("rst_wren", 32'(o_rd_wren), 32'd0);
      chk("rst_addr", 32'(o_rd_addr), 32'd0);
      chk("rst_data", o_rd_data, 32'd0);
      chk("rst_retire", 32'(o_retire), 32'd0);
      chk("rst_instret", o_instret, 32'd0);
    end else begin
      chk("wren", 32'(o_rd_wren), 32'(m_v && m_we && (m_addr != 0)));
      chk("addr", 32'(o_rd_addr), 32'(m_addr));
      chk("data", o_rd_data, m_data);
      chk("retire", 32'(o_retire), 32'(m_v));
`ifdef WB_INSTRET_EN
      chk("instret", o_instret, m_cnt);
`else
      chk("instret", o_instret, 32'd0);
`endif
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic we,
                       input logic [4:0] a, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [2:0] f3, input logic [31:0] p);
    valid = v; stall = s; flush = f; rd_we = we; rd_addr = a; wb_sel = sel;
    alu_result = alu; ld_data = ld; ld_funct3 = f3; pc = p;
  endtask

  initial begin
    m_v = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset for 4 cycles, then idle
    repeat (4) cyc();
    rst = 1'b0;
    cyc();

    // ALU write to x2
    drive(1, 0, 0, 1, 5'd2, 2'b00, 32'h0041_0133, 32'h0, 3'd0, 32'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // loads at byte offset 1 for each width
    foreach (ld_funct3_list[i]) begin
      drive(1, 0, 0, 1, 5'd7, 2'b01, 32'h0000_1001, 32'h8081_F0F7, ld_funct3_list[i], 32'h0);
      cyc();
      chk("load_const", o_rd_data, ld_expect_list[i]);
    end

    // PC+4 wraps; x0 write suppressed but still retires
    drive(1, 0, 0, 1, 5'd9, 2'b10, 32'h0, 32'h0, 3'd0, 32'hFFFF_FFFC);
    cyc();
    chk("pc_wrap", o_rd_data, 32'h0);
    drive(1, 0, 0, 1, 5'd0, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'd0, 32'h0);
    cyc();
    chk("x0_wren", 32'(o_rd_wren), 32'd0);
    chk("x0_retire", 32'(o_retire), 32'd1);

    // stall two cycles then flush one: three bubbles
    drive(1, 1, 0, 1, 5'd3, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 32'h0);
    cyc(); cyc();
    drive(1, 0, 1, 1, 5'd3, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 32'h0);
    cyc();

    // reset mid-stream with a valid entry held in the stage
    drive(1, 0, 0, 1, 5'd4, 2'b00, 32'h5555_AAAA, 32'h0, 3'd0, 32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    valid = 1'b0;
    cyc();

`ifdef WB_INSTRET_EN
    // counter wrap: preload all-ones, retire once more
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 0, 0, 1, 5'd1, 2'b00, 32'h1, 32'h0, 3'd0, 32'h0);
    cyc();
    valid = 1'b0;
    cyc();
    chk("instret_wrap", o_instret, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 39) == 0);
      valid      = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 6) == 0);
      flush      = ($urandom_range(0, 6) == 0);
      rd_we      = ($urandom_range(0, 4) != 0);
      rd_addr    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      wb_sel     = 2'($urandom);
      alu_result = $urandom;
      ld_data    = $urandom;
      ld_funct3  = 3'($urandom);
      pc         = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  logic [2:0]  ld_funct3_list [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [31:0] ld_expect_list [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_F0F7,
                                      32'h0000_F0F7, 32'h8081_F0F7};

endmodule
